// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencer with separate
// instruction and data memory handshakes and a combinational register debug port.
module multicycle_mips_core #(
  parameter int              DATA_W   = 32,
  parameter int              REG_N    = 32,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [31:0]               imem_rdata,
  input  logic                      imem_ready,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_W-1:0]         dmem_addr,
  output logic [DATA_W-1:0]         dmem_wdata,
  input  logic [DATA_W-1:0]         dmem_rdata,
  input  logic                      dmem_ready,
  input  logic [$clog2(REG_N)-1:0]  dbg_sel,
  output logic [DATA_W-1:0]         dbg_data,
  output logic [ADDR_W-1:0]         pc,
  output logic                      retire,
  output logic                      illegal,
  output logic                      halted
);

  localparam int RIDX_W = $clog2(REG_N);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, state_n;

  logic [31:0]       ir;
  logic [DATA_W-1:0] a_reg, b_reg, imm_reg, alu_reg, mdr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] regs [REG_N];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, shamt, wb_idx;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val, alu_res, wb_data;
  logic              funct_ok, br_take, pc_we, reg_we;
  logic [ADDR_W-1:0] pc_n, pc_plus4, br_off, j_target;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm16 = ir[15:0];

  assign imm_ext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign pc_plus4 = pc + ADDR_W'(4);
  assign br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  // Jump keeps the top four bits of pc+4; assumes ADDR_W > 28.
  assign j_target = {pc_plus4[ADDR_W-1:28], ir[25:0], 2'b00};
  assign br_take  = (a_reg == b_reg) ^ (op == OP_BNE);

  assign imem_addr  = pc;
  assign dmem_addr  = mem_addr;
  assign dmem_wdata = b_reg;
  assign halted     = (state == S_HALT);

  assign wb_idx  = (op == OP_R) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_reg;

  // Register reads; r0 and indices beyond REG_N read as zero.
  always_comb begin
    rs_val   = '0;
    rt_val   = '0;
    dbg_data = '0;
    if (rs != 5'd0 && int'(rs) < REG_N) rs_val = regs[RIDX_W'(rs)];
    if (rt != 5'd0 && int'(rt) < REG_N) rt_val = regs[RIDX_W'(rt)];
    if (dbg_sel != '0 && int'(dbg_sel) < REG_N) dbg_data = regs[dbg_sel];
  end

  always_comb begin
    alu_res  = a_reg + imm_reg;
    funct_ok = 1'b1;
    if (op == OP_R) begin
      unique case (funct)
        FN_ADD:  alu_res = a_reg + b_reg;
        FN_SUB:  alu_res = a_reg - b_reg;
        FN_AND:  alu_res = a_reg & b_reg;
        FN_OR:   alu_res = a_reg | b_reg;
        FN_SLT:  alu_res = DATA_W'($signed(a_reg) < $signed(b_reg));
        FN_SLL:  alu_res = b_reg << shamt;
        FN_SRL:  alu_res = b_reg >> shamt;
        default: begin
          alu_res  = '0;
          funct_ok = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // Handshakes: a request is held with stable address/data/we until the matching
  // ready is sampled high on a rising edge; that edge completes the transfer.
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    pc_we    = 1'b0;
    pc_n     = pc_plus4;
    reg_we   = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_n = S_DECODE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        unique case (op)
          OP_R, OP_ADDI: begin
            if (funct_ok) begin
              state_n = S_WB;
            end else begin
              retire  = 1'b1;
              illegal = 1'b1;
              pc_we   = 1'b1;
              state_n = S_FETCH;
            end
          end
          OP_LW, OP_SW: state_n = S_MEM;
          OP_BEQ, OP_BNE: begin
            retire  = 1'b1;
            pc_we   = 1'b1;
            pc_n    = br_take ? pc_plus4 + br_off : pc_plus4;
            state_n = S_FETCH;
          end
          OP_J: begin
            retire  = 1'b1;
            pc_we   = 1'b1;
            pc_n    = j_target;
            state_n = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_n = S_HALT;
          end
          default: begin
            retire  = 1'b1;
            illegal = 1'b1;
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ready) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            pc_we   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = (wb_idx != 5'd0) && (int'(wb_idx) < REG_N);
        retire  = 1'b1;
        pc_we   = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
    // Reset must withdraw any outstanding request immediately.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      imm_reg  <= '0;
      alu_reg  <= '0;
      mdr      <= '0;
      mem_addr <= '0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      if (pc_we) pc <= pc_n;
      unique case (state)
        S_FETCH:  if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          a_reg   <= rs_val;
          b_reg   <= rt_val;
          imm_reg <= imm_ext;
        end
        S_EXEC: begin
          alu_reg  <= alu_res;
          mem_addr <= ADDR_W'(a_reg + imm_reg);
        end
        S_MEM:    if (dmem_ready && op == OP_LW) mdr <= dmem_rdata;
        S_WB:     if (reg_we) regs[RIDX_W'(wb_idx)] <= wb_data;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Directed bench for multicycle_mips_core: single-instruction vector table plus
// hand-written sequences for memory waits, branches, illegal ops, halt and reset.
module tb_multicycle_mips_core;

  localparam logic [31:0] HALT_I = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  dbg_sel = 5'd0;
  logic [31:0] dbg_data, pc;
  logic        retire, illegal, halted;

  multicycle_mips_core dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
    .retire(retire), .illegal(illegal), .halted(halted)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int idelay = 0, ddelay = 0;
  int icnt = 0, dcnt = 0;
  int cyc = 0;

  assign imem_ready = imem_req && (icnt == idelay);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt == ddelay);
  assign dmem_rdata = dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    cyc++;
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[7:2]] = dmem_wdata;
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input logic [79:0] act, input logic [79:0] exp, input string tag);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic chk_reg(input int idx, input logic [31:0] exp, input string tag);
    dbg_sel = idx[4:0];
    #1;
    chk(dbg_data, exp, tag);
  endtask

  // Scoreboard: each expected retire is {illegal, pc}.
  logic [32:0] exp_q[$];
  int          t_q[$];
  int          rcnt = 0;
  bit          mon_on = 1'b0;
  bit          prev_wait = 1'b0;
  logic [64:0] prev_bus;

  always @(negedge clk) begin
    if (mon_on) begin
      if (illegal) chk(retire, 1, "illegal_with_retire");
      if (retire) begin
        t_q.push_back(cyc);
        rcnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_retire: got pc %0h expected no retire", pc);
        end else begin
          chk({illegal, pc}, exp_q.pop_front(), "retire_pc");
        end
      end
      if (dmem_req && prev_wait) chk({dmem_we, dmem_addr, dmem_wdata}, prev_bus, "dmem_stable");
      prev_wait = dmem_req && !dmem_ready;
      prev_bus  = {dmem_we, dmem_addr, dmem_wdata};
    end else begin
      prev_wait = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = HALT_I;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    mon_on = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    t_q.delete();
    rcnt   = 0;
    mon_on = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic run(input int max_cyc, input int stop_ret);
    bit done = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      if (halted || rcnt >= stop_ret) begin
        done = 1'b1;
        break;
      end
    end
    if (rcnt >= stop_ret) mon_on = 1'b0;
    chk(done, 1, "timeout");
  endtask

  task automatic chk_lat(input int i, input int exp, input string tag);
    if (t_q.size() > i) chk(t_q[i] - t_q[i-1], exp, tag);
    else chk(t_q.size(), i + 1, {tag, "_missing"});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int nreq;
    vt[0]  = '{r_ins(1, 2, 3, 0, 6'h20), 32'd5,        32'd7,        32'd12};
    vt[1]  = '{r_ins(1, 2, 3, 0, 6'h22), 32'd5,        32'd7,        32'hFFFFFFFE};
    vt[2]  = '{r_ins(1, 2, 3, 0, 6'h24), 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vt[3]  = '{r_ins(1, 2, 3, 0, 6'h25), 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
    vt[4]  = '{r_ins(1, 2, 3, 0, 6'h2A), 32'hFFFFFFFF, 32'd1,        32'd1};
    vt[5]  = '{r_ins(1, 2, 3, 0, 6'h2A), 32'd1,        32'hFFFFFFFF, 32'd0};
    vt[6]  = '{r_ins(1, 2, 3, 4, 6'h00), 32'd0,        32'd1,        32'h10};
    vt[7]  = '{r_ins(1, 2, 3, 31, 6'h02), 32'd0,       32'h80000000, 32'd1};
    vt[8]  = '{i_ins(6'h08, 1, 3, 16'hFFFD), 32'd5,    32'd0,        32'd2};
    vt[9]  = '{r_ins(1, 2, 3, 0, 6'h20), 32'hFFFFFFFF, 32'd1,        32'd0};
    vt[10] = '{r_ins(1, 2, 3, 0, 6'h22), 32'd0,        32'd1,        32'hFFFFFFFF};

    // Reset state
    clear_mem();
    #2;
    chk(imem_req, 0, "rst_imem_req");
    chk(dmem_req, 0, "rst_dmem_req");
    chk({retire, illegal, halted}, 0, "rst_flags");
    chk(pc, 0, "rst_pc");
    chk_reg(5, 0, "rst_reg5");

    // Table: load r1/r2 from memory, run one instruction, halt.
    for (int i = 0; i < 11; i++) begin
      clear_mem();
      dmem[0] = vt[i].a;
      dmem[1] = vt[i].b;
      imem[0] = i_ins(6'h23, 0, 1, 16'd0);
      imem[1] = i_ins(6'h23, 0, 2, 16'd4);
      imem[2] = vt[i].instr;
      do_reset();
      exp_q = '{33'h0, 33'h4, 33'h8, 33'hC};
      run(200, 1000);
      @(negedge clk);
      chk_reg(3, vt[i].exp, $sformatf("vec%0d_r3", i));
      chk_lat(2, 4, $sformatf("vec%0d_lat", i));
      if (i == 0) chk_lat(1, 5, "lw_lat_zero_wait");
      chk(exp_q.size(), 0, "vec_retires_left");
    end

    // ADDI/ADDI/ADD, zero wait
    clear_mem();
    imem[0] = i_ins(6'h08, 0, 1, 16'd5);
    imem[1] = i_ins(6'h08, 0, 2, 16'd7);
    imem[2] = r_ins(1, 2, 3, 0, 6'h20);
    do_reset();
    exp_q = '{33'h0, 33'h4, 33'h8, 33'hC};
    run(200, 1000);
    @(negedge clk);
    chk_reg(3, 12, "seq_r3");
    chk_lat(1, 4, "addi_lat");
    chk_lat(2, 4, "add_lat");
    chk(pc, 12, "seq_pc_halt");
    chk(halted, 1, "seq_halted");

    // SW then LW with 3-cycle dmem wait
    clear_mem();
    ddelay  = 3;
    imem[0] = i_ins(6'h08, 0, 3, 16'd12);
    imem[1] = i_ins(6'h2B, 0, 3, 16'd8);
    imem[2] = i_ins(6'h23, 0, 4, 16'd8);
    do_reset();
    exp_q = '{33'h0, 33'h4, 33'h8, 33'hC};
    run(200, 1000);
    @(negedge clk);
    chk_reg(4, 12, "lw_r4");
    chk(dmem[2], 12, "sw_mem");
    chk_lat(1, 7, "sw_lat_wait");
    chk_lat(2, 8, "lw_lat_wait");
    ddelay = 0;

    // BEQ to itself at 0x20
    clear_mem();
    imem[0] = i_ins(6'h08, 0, 1, 16'd5);
    imem[1] = {6'h02, 26'd8};
    imem[8] = i_ins(6'h04, 1, 1, 16'hFFFF);
    do_reset();
    exp_q = '{33'h0, 33'h4, 33'h20, 33'h20, 33'h20};
    run(200, 5);
    @(negedge clk);
    chk(pc, 32'h20, "beq_pc");
    chk_lat(2, 3, "j_lat");
    chk_lat(3, 3, "beq_lat");
    chk_lat(4, 3, "beq_lat2");

    // BNE on equal registers falls through
    imem[8] = i_ins(6'h05, 1, 1, 16'hFFFF);
    do_reset();
    exp_q = '{33'h0, 33'h4, 33'h20, 33'h24};
    run(200, 1000);
    @(negedge clk);
    chk(pc, 32'h24, "bne_pc");
    chk(exp_q.size(), 0, "bne_retires_left");

    // r0 is hardwired to zero
    clear_mem();
    imem[0] = i_ins(6'h08, 0, 0, 16'd9);
    imem[1] = i_ins(6'h08, 0, 1, 16'd1);
    do_reset();
    exp_q = '{33'h0, 33'h4, 33'h8};
    run(200, 1000);
    @(negedge clk);
    chk_reg(0, 0, "r0_zero");
    chk_reg(1, 1, "r0_reads_zero");

    // Illegal opcode and funct, then HALT stays quiet
    clear_mem();
    imem[0] = 32'hF8000000;
    imem[1] = r_ins(1, 2, 3, 0, 6'h3F);
    imem[2] = i_ins(6'h08, 0, 1, 16'd5);
    do_reset();
    exp_q = '{{1'b1, 32'h0}, {1'b1, 32'h4}, 33'h8, 33'hC};
    run(200, 1000);
    @(negedge clk);
    chk_reg(3, 0, "illegal_no_write");
    chk_reg(1, 5, "after_illegal_r1");
    chk(halted, 1, "halted");
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) nreq++;
    end
    chk(nreq, 0, "halt_no_req");
    chk(rcnt, 4, "halt_no_retire");
    chk(halted, 1, "halt_sticky");

    // Reset while a fetch waits on imem_ready
    clear_mem();
    imem[0] = i_ins(6'h08, 0, 1, 16'd5);
    imem[1] = i_ins(6'h08, 0, 2, 16'd7);
    do_reset();
    exp_q = '{33'h0};
    run(100, 1);
    idelay = 50;
    @(negedge clk);
    chk(imem_req, 1, "wait_req");
    chk(pc, 4, "wait_pc");
    chk_reg(1, 5, "wait_r1");
    repeat (3) @(negedge clk);
    chk(imem_addr, 4, "wait_addr_stable");
    rst = 1'b1;
    #1;
    chk(imem_req, 0, "rst_drop_req");
    chk(pc, 0, "rst_mid_pc");
    chk_reg(1, 0, "rst_mid_r1");
    idelay = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(pc, 0, "release_pc");
    chk(imem_req, 1, "release_req");
    chk_reg(2, 0, "release_r2");
    chk(rcnt, 1, "rst_no_completion");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
